// File: rtl/router_sched_pkg.sv
// router_sched_pkg: state encoding and settle timing shared by the router select scheduler.
package router_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, DRAIN} state_e;
  localparam int SETTLE_CYC = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_ptr_i+1 with wrap.
module rr_arbiter #(
  parameter int PORTS = 4,
  parameter int W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [W-1:0]     last_ptr_i,
  output logic [W-1:0]     winner_o,
  output logic             valid_o
);
  logic [W-1:0] idx;
  always_comb begin
    winner_o = '0;
    valid_o = 1'b0;
    idx = '0;
    for (int i = PORTS; i >= 1; i--) begin
      idx = W'((int'(last_ptr_i) + i) % PORTS);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/router_sel_scheduler.sv
// router_sel_scheduler: isolates, selects and grants one router input at a time.
// Define ROUTER_SCHED_STARVE_MON_EN to add per-port wait counters and the starve_o output.
module router_sel_scheduler
  import router_sched_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int QUOTA = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         req_i,
  input  logic                     beat_fire_i,
  input  logic                     last_i,
  input  logic                     force_isolate_i,
  output logic [$clog2(PORTS)-1:0] sel_o,
  output logic                     isolate_o,
  output logic [PORTS-1:0]         grant_o,
  output logic                     abort_o,
  output logic                     busy_o
`ifdef ROUTER_SCHED_STARVE_MON_EN
  ,
  output logic [PORTS-1:0]         starve_o
`endif
);
  localparam int W = $clog2(PORTS);
  state_e state_q, state_d;
  logic [W-1:0] sel_q, sel_d, last_q, last_d, win_idx;
  logic [PORTS-1:0] grant_q, grant_d, sel_hot;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] settle_q, settle_d;
  logic iso_q, iso_d, abort_q, abort_d, busy_q, busy_d, burst_q, burst_d;
  logic win_vld, other_req, quota_hit, exit_now;

  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .req_i(req_i), .last_ptr_i(last_q), .winner_o(win_idx), .valid_o(win_vld)
  );

  assign sel_hot = PORTS'(1) << sel_q;
  assign other_req = |(req_i & ~sel_hot);
  assign quota_hit = cnt_q == 8'(QUOTA);
  // A quota exit is held off while a burst is open or about to open this cycle.
  assign exit_now = (beat_fire_i && last_i) || (quota_hit && other_req && !burst_q && !beat_fire_i) ||
                    (!req_i[sel_q] && !burst_q) || force_isolate_i;

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    settle_d = settle_q;
    iso_d = iso_q;
    burst_d = burst_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (win_vld && !force_isolate_i) begin
        state_d = SETTLE;
        sel_d = win_idx;
        settle_d = '0;
      end
      SETTLE: begin
        settle_d = settle_q + 2'd1;
        if (settle_q == 2'(SETTLE_CYC - 1)) begin
          state_d = ACTIVE;
          iso_d = 1'b0;
          grant_d = sel_hot;
          cnt_d = '0;
          burst_d = 1'b0;
        end
      end
      ACTIVE: begin
        cnt_d = quota_hit ? (other_req ? cnt_q : {7'd0, beat_fire_i}) : cnt_q + {7'd0, beat_fire_i};
        burst_d = beat_fire_i ? !last_i : burst_q;
        if (exit_now) begin
          state_d = DRAIN;
          iso_d = 1'b1;
          grant_d = '0;
          abort_d = force_isolate_i && burst_q;
          cnt_d = '0;
          burst_d = 1'b0;
        end
      end
      DRAIN: begin
        last_d = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      last_q <= W'(PORTS - 1);
      grant_q <= '0;
      cnt_q <= '0;
      settle_q <= '0;
      iso_q <= 1'b1;
      burst_q <= 1'b0;
      abort_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      settle_q <= settle_d;
      iso_q <= iso_d;
      burst_q <= burst_d;
      abort_q <= abort_d;
      busy_q <= busy_d;
    end
  end

  assign sel_o = sel_q;
  assign isolate_o = iso_q;
  assign grant_o = grant_q;
  assign abort_o = abort_q;
  assign busy_o = busy_q;

`ifdef ROUTER_SCHED_STARVE_MON_EN
  logic [PORTS-1:0][7:0] wait_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else for (int i = 0; i < PORTS; i++)
      wait_q[i] <= grant_q[i] ? 8'd0 : (req_i[i] && wait_q[i] != 8'hff) ? wait_q[i] + 8'd1 : wait_q[i];
  end
  for (genvar g = 0; g < PORTS; g++) begin : g_starve
    assign starve_o[g] = &wait_q[g];
  end
`endif
endmodule

// File: tb/tb_router_sel_scheduler.sv
// tb_router_sel_scheduler: directed stimulus pushes expected grant/abort events; a negedge monitor pops and compares them.
module tb_router_sel_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_i = '0;
  logic beat_fire_i = 1'b0, last_i = 1'b0, force_isolate_i = 1'b0;
  logic [1:0] sel_o;
  logic isolate_o, abort_o, busy_o;
  logic [3:0] grant_o;
`ifdef ROUTER_SCHED_STARVE_MON_EN
  logic [3:0] starve_o;
`endif

  typedef struct {
    bit abort;
    logic [3:0] grant;
    logic [1:0] sel;
    int gap;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, iso_run = 0;
  logic [3:0] prev_grant = '0;

  router_sel_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .beat_fire_i(beat_fire_i), .last_i(last_i),
    .force_isolate_i(force_isolate_i), .sel_o(sel_o), .isolate_o(isolate_o), .grant_o(grant_o),
    .abort_o(abort_o), .busy_o(busy_o)
`ifdef ROUTER_SCHED_STARVE_MON_EN
    , .starve_o(starve_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_g(input logic [3:0] g, input logic [1:0] s, input int gap);
    exp_q.push_back('{1'b0, g, s, gap});
  endfunction

  function automatic void push_a();
    exp_q.push_back('{1'b1, 4'b0, 2'b0, -1});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0;
    beat_fire_i = 1'b0;
    last_i = 1'b0;
    force_isolate_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (grant_o == '0 && n < 30) begin
      tick();
      n++;
    end
    chk(name, 32'(grant_o != '0), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (grant_o != '0 && prev_grant == '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_event: got grant=%b with no event expected", grant_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.abort || grant_o !== mon_e.grant || sel_o !== mon_e.sel || (mon_e.gap >= 0 && iso_run != mon_e.gap)) begin
          errors++;
          $display("FAIL grant_event: got grant=%b sel=%0d gap=%0d expected abort=%0b grant=%b sel=%0d gap=%0d",
                   grant_o, sel_o, iso_run, mon_e.abort, mon_e.grant, mon_e.sel, mon_e.gap);
        end
      end
    end
    if (abort_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL abort_event: got abort pulse with no event expected");
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.abort) begin
          errors++;
          $display("FAIL abort_event: got abort pulse expected grant=%b", mon_e.grant);
        end
      end
    end
    iso_run = isolate_o ? iso_run + 1 : 0;
    prev_grant = grant_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_isolate", 32'(isolate_o), 32'd1);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_abort", 32'(abort_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    // Single requester: latency sel at +1, isolate low at +3.
    rst_n = 1'b1;
    push_g(4'b0001, 2'd0, -1);
    req_i = 4'b0001;
    tick();
    chk("lat_c1_sel", 32'(sel_o), 32'd0);
    chk("lat_c1_busy", 32'(busy_o), 32'd1);
    chk("lat_c1_iso", 32'(isolate_o), 32'd1);
    tick();
    chk("lat_c2_iso", 32'(isolate_o), 32'd1);
    tick();
    chk("lat_c3_iso", 32'(isolate_o), 32'd0);
    chk("lat_c3_grant", 32'(grant_o), 32'b0001);
    req_i = '0;
    tick();
    chk("drop_iso", 32'(isolate_o), 32'd1);
    chk("drop_grant", 32'(grant_o), 32'd0);
    chk("drain_busy", 32'(busy_o), 32'd1);
    tick();
    chk("idle_busy", 32'(busy_o), 32'd0);
    wait_drain("t1_drain");
    // All ports requesting with single-beat bursts: rotation 0,1,2,3,0.
    do_reset();
    push_g(4'b0001, 2'd0, -1);
    push_g(4'b0010, 2'd1, 4);
    push_g(4'b0100, 2'd2, 4);
    push_g(4'b1000, 2'd3, 4);
    push_g(4'b0001, 2'd0, 4);
    req_i = 4'b1111;
    beat_fire_i = 1'b1;
    last_i = 1'b1;
    wait_drain("rr_drain");
    req_i = '0;
    beat_fire_i = 1'b0;
    last_i = 1'b0;
    repeat (4) tick();
    // Port 1 bursts past the quota while port 2 waits.
    do_reset();
    push_g(4'b0010, 2'd1, -1);
    push_g(4'b0100, 2'd2, 4);
    req_i = 4'b0110;
    wait_grant("q_grant1");
    beat_fire_i = 1'b1;
    repeat (12) tick();
    chk("q_past_quota_grant", 32'(grant_o), 32'b0010);
    chk("q_past_quota_iso", 32'(isolate_o), 32'd0);
    last_i = 1'b1;
    tick();
    chk("q_last_iso", 32'(isolate_o), 32'd1);
    chk("q_last_grant", 32'(grant_o), 32'd0);
    req_i = 4'b0100;
    wait_drain("q_drain");
    req_i = '0;
    beat_fire_i = 1'b0;
    last_i = 1'b0;
    repeat (4) tick();
    // Sole requester streams 20 beats: grant never drops; then async reset mid-burst.
    do_reset();
    push_g(4'b0010, 2'd1, -1);
    req_i = 4'b0010;
    wait_grant("solo_grant");
    beat_fire_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 8 || i == 9 || i == 16 || i == 17 || i == 20) chk($sformatf("solo_beat%0d", i), 32'({isolate_o, grant_o}), 32'b00010);
    end
    #2;
    rst_n = 1'b0;
    req_i = '0;
    beat_fire_i = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel_o), 32'd0);
    chk("async_rst_iso", 32'(isolate_o), 32'd1);
    chk("async_rst_grant", 32'(grant_o), 32'd0);
    chk("async_rst_abort", 32'(abort_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_drain("solo_drain");
    // Forced isolation at beat 3 of a burst aborts and holds IDLE.
    do_reset();
    push_g(4'b0001, 2'd0, -1);
    push_a();
    req_i = 4'b0001;
    wait_grant("f_grant");
    beat_fire_i = 1'b1;
    tick();
    tick();
    force_isolate_i = 1'b1;
    tick();
    chk("f_iso", 32'(isolate_o), 32'd1);
    chk("f_abort", 32'(abort_o), 32'd1);
    chk("f_grant_off", 32'(grant_o), 32'd0);
    beat_fire_i = 1'b0;
    tick();
    chk("f_abort_once", 32'(abort_o), 32'd0);
    repeat (5) tick();
    chk("f_hold_busy", 32'(busy_o), 32'd0);
    chk("f_hold_iso", 32'(isolate_o), 32'd1);
    chk("f_hold_grant", 32'(grant_o), 32'd0);
    push_g(4'b0001, 2'd0, -1);
    force_isolate_i = 1'b0;
    wait_grant("f_regrant");
    req_i = '0;
    wait_drain("f_drain");
    repeat (3) tick();
`ifdef ROUTER_SCHED_STARVE_MON_EN
    do_reset();
    push_g(4'b0001, 2'd0, -1);
    req_i = 4'b0001;
    wait_grant("st_grant");
    req_i = 4'b1001;
    repeat (254) tick();
    chk("starve_254", 32'(starve_o), 32'd0);
    tick();
    chk("starve_255", 32'(starve_o), 32'b1000);
    req_i = '0;
    wait_drain("st_drain");
    repeat (3) tick();
`endif
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
